// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and FSM state type for the memory access controller
package mem_pkg;

  localparam logic [1:0] MODE_BYTE     = 2'b00;
  localparam logic [1:0] MODE_HALFWORD = 2'b01;
  localparam logic [1:0] MODE_WORD     = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL  = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RELEASE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - zero/sign extension of right-aligned RAM read data
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic        sign_ext,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  // widen byte and halfword loads; words and anything else pass through
  always_comb begin
    ext = data;
    case (mode)
      MODE_BYTE:     ext = {{24{sign_ext & data[7]}}, data[7:0]};
      MODE_HALFWORD: ext = {{16{sign_ext & data[15]}}, data[15:0]};
      default:       ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - RAM handshake initiator FSM with timeout; ALIGN_CHECK_EN rejects unaligned accesses
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        mode,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_enable,
  output logic              mem_w_r,
  output logic [1:0]        mem_access_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_out,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_moc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic              lat_rw;
  logic              lat_sext;
  logic [1:0]        lat_mode;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       ext_data;
  logic [31:0]       cap_data;
  logic [CNT_W-1:0]  cnt;
  logic              bad_req;

  load_extend u_load_extend (
    .mode     (lat_mode),
    .sign_ext (lat_sext),
    .data     (mem_data_in),
    .ext      (ext_data)
  );

  // requests that complete with err without ever touching the RAM
  always_comb begin
    bad_req = (mode == MODE_ILLEGAL);
`ifdef ALIGN_CHECK_EN
    if (mode == MODE_HALFWORD && addr[0] != 1'b0) bad_req = 1'b1;
    if (mode == MODE_WORD && addr[1:0] != 2'b00) bad_req = 1'b1;
`endif
  end

  // transaction sequencer: drive, wait for MOC, release, complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      rdata           <= '0;
      mem_enable      <= 1'b0;
      mem_w_r         <= RW_READ;
      mem_access_mode <= MODE_BYTE;
      mem_address     <= '0;
      mem_data_out    <= '0;
      lat_rw          <= RW_READ;
      lat_sext        <= 1'b0;
      lat_mode        <= MODE_BYTE;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      cap_data        <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_rw    <= rw;
            lat_sext  <= sign_ext;
            lat_mode  <= mode;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            busy      <= 1'b1;
            if (bad_req) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          mem_address     <= lat_addr;
          mem_access_mode <= lat_mode;
          mem_w_r         <= lat_rw;
          mem_data_out    <= lat_wdata;
          mem_enable      <= 1'b0;
          cnt             <= '0;
          state           <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (mem_moc) begin
            if (lat_rw == RW_READ) cap_data <= ext_data;
            mem_enable <= 1'b0;
            cnt        <= '0;
            state      <= ST_RELEASE;
          end else if (cnt == CNT_LAST) begin
            mem_enable <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b1;
            state      <= ST_DONE;
          end else begin
            mem_enable <= 1'b1;
            cnt        <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          mem_enable <= 1'b0;
          if (!mem_moc) begin
            // read data is committed only for a cleanly completed read
            if (lat_rw == RW_READ) rdata <= cap_data;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed-vector bench for mem_access_ctrl with a behavioural RAM
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        sign_ext = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_enable, mem_w_r;
  logic [1:0]  mem_access_mode;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_moc = 1'b0;

  logic [7:0]  ram [256];
  logic        moc_off = 1'b0;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int done_cnt = 0;
  int en_rises = 0;
  logic       en_prev = 1'b0;
  logic [7:0] last_addr = '0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .rw              (rw),
    .mode            (mode),
    .sign_ext        (sign_ext),
    .addr            (addr),
    .wdata           (wdata),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .rdata           (rdata),
    .mem_enable      (mem_enable),
    .mem_w_r         (mem_w_r),
    .mem_access_mode (mem_access_mode),
    .mem_address     (mem_address),
    .mem_data_out    (mem_data_out),
    .mem_data_in     (mem_data_in),
    .mem_moc         (mem_moc)
  );

  always #5 clk = ~clk;

  // little-endian RAM: answers one cycle after enable, releases MOC once enable drops
  always @(posedge clk) begin
    if (mem_enable && !moc_off && !mem_moc) begin
      mem_moc <= 1'b1;
      if (mem_w_r) begin
        case (mem_access_mode)
          2'b00:   mem_data_in <= {24'h0, ram[mem_address]};
          2'b01:   mem_data_in <= {16'h0, ram[mem_address + 8'd1], ram[mem_address]};
          default: mem_data_in <= {ram[mem_address + 8'd3], ram[mem_address + 8'd2],
                                   ram[mem_address + 8'd1], ram[mem_address]};
        endcase
      end else begin
        ram[mem_address] <= mem_data_out[7:0];
        if (mem_access_mode != 2'b00) ram[mem_address + 8'd1] <= mem_data_out[15:8];
        if (mem_access_mode == 2'b10) begin
          ram[mem_address + 8'd2] <= mem_data_out[23:16];
          ram[mem_address + 8'd3] <= mem_data_out[31:24];
        end
      end
    end else if (!mem_enable) begin
      mem_moc <= 1'b0;
    end
  end

  // count done pulses and RAM cycle starts
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (mem_enable && !en_prev) begin
      en_rises++;
      last_addr = mem_address;
    end
    en_prev = mem_enable;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic r, input logic [1:0] m, input logic s,
                       input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    rw = r; mode = m; sign_ext = s; addr = a; wdata = w; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic e, output int lat);
    int d0;
    d0 = done_cnt;
    lat = 0;
    while (done !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    check_val("done_seen", {31'b0, done}, 32'd1);
    e = err;
    @(negedge clk);
    check_val("done_once", done_cnt - d0, 32'd1);
    check_val("busy_clear", {31'b0, busy}, 32'd0);
  endtask

  logic e;
  int   lat;
  int   n0;

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_err", {31'b0, err}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_en", {31'b0, mem_enable}, 32'd0);
    check_val("rst_wr", {31'b0, mem_w_r}, 32'd1);
    check_val("rst_mode", {30'b0, mem_access_mode}, 32'd0);
    check_val("rst_addr", {24'b0, mem_address}, 32'd0);
    check_val("rst_dout", mem_data_out, 32'd0);
    reset = 1'b0;

    // byte write 0x85 at 0x04
    issue(1'b0, 2'b00, 1'b0, 8'h04, 32'h0000_0085);
    check_val("bw_busy", {31'b0, busy}, 32'd1);
    wait_done(40, e, lat);
    check_val("bw_err", {31'b0, e}, 32'd0);
    check_val("bw_ram", {24'b0, ram[4]}, 32'h85);

    // byte read, sign- then zero-extended
    issue(1'b1, 2'b00, 1'b1, 8'h04, 32'h0);
    wait_done(40, e, lat);
    check_val("br_s_err", {31'b0, e}, 32'd0);
    check_val("br_s_data", rdata, 32'hFFFF_FF85);
    issue(1'b1, 2'b00, 1'b0, 8'h04, 32'h0);
    wait_done(40, e, lat);
    check_val("br_z_data", rdata, 32'h0000_0085);

    // word write 0xDEADBEEF at 0x08: enable rises two edges after accept
    issue(1'b0, 2'b10, 1'b0, 8'h08, 32'hDEAD_BEEF);
    check_val("ww_en_e0", {31'b0, mem_enable}, 32'd0);
    @(negedge clk);
    check_val("ww_en_e1", {31'b0, mem_enable}, 32'd0);
    @(negedge clk);
    check_val("ww_en_e2", {31'b0, mem_enable}, 32'd1);
    check_val("ww_wr", {31'b0, mem_w_r}, 32'd0);
    check_val("ww_mode", {30'b0, mem_access_mode}, 32'd2);
    check_val("ww_addr", {24'b0, mem_address}, 32'h08);
    check_val("ww_dout", mem_data_out, 32'hDEAD_BEEF);
    wait_done(40, e, lat);
    check_val("ww_err", {31'b0, e}, 32'd0);
    check_val("ww_ram", {ram[11], ram[10], ram[9], ram[8]}, 32'hDEAD_BEEF);
    check_val("ww_rdata_kept", rdata, 32'h0000_0085);

    // word read back, with a stray request while busy that must be ignored
    n0 = en_rises;
    issue(1'b1, 2'b10, 1'b0, 8'h08, 32'h0);
    @(negedge clk);
    rw = 1'b0; mode = 2'b11; addr = 8'h20; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done(40, e, lat);
    check_val("wr_err", {31'b0, e}, 32'd0);
    check_val("wr_data", rdata, 32'hDEAD_BEEF);
    check_val("wr_one_cycle", en_rises - n0, 32'd1);

    // halfword sign-extended read of 0xBEEF
    issue(1'b1, 2'b01, 1'b1, 8'h08, 32'h0);
    wait_done(40, e, lat);
    check_val("hr_data", rdata, 32'hFFFF_BEEF);

    // illegal mode: done with err one cycle after accept, no RAM cycle
    n0 = en_rises;
    issue(1'b1, 2'b11, 1'b0, 8'h00, 32'h0);
    wait_done(40, e, lat);
    check_val("ill_err", {31'b0, e}, 32'd1);
    check_val("ill_lat", lat, 32'd0);
    check_val("ill_no_en", en_rises - n0, 32'd0);
    check_val("ill_rdata", rdata, 32'hFFFF_BEEF);

    // MOC never arrives: timeout
    moc_off = 1'b1;
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h0);
    wait_done(TO + 20, e, lat);
    check_val("to_err", {31'b0, e}, 32'd1);
    check_val("to_lat_ok", {31'b0, (lat >= TO && lat <= TO + 3)}, 32'd1);
    check_val("to_en", {31'b0, mem_enable}, 32'd0);
    check_val("to_rdata", rdata, 32'hFFFF_BEEF);

    // reset while in ACCESS
    n0 = done_cnt;
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h0);
    repeat (2) @(negedge clk);
    check_val("rm_en_pre", {31'b0, mem_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("rm_en", {31'b0, mem_enable}, 32'd0);
    check_val("rm_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    moc_off = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rm_no_done", done_cnt - n0, 32'd0);
    issue(1'b1, 2'b00, 1'b0, 8'h04, 32'h0);
    wait_done(40, e, lat);
    check_val("rm_next_err", {31'b0, e}, 32'd0);
    check_val("rm_next_data", rdata, 32'h0000_0085);

    // unaligned halfword at 0x03
    n0 = en_rises;
    issue(1'b1, 2'b01, 1'b0, 8'h03, 32'h0);
    wait_done(40, e, lat);
`ifdef ALIGN_CHECK_EN
    check_val("al_err", {31'b0, e}, 32'd1);
    check_val("al_no_en", en_rises - n0, 32'd0);
`else
    check_val("al_err", {31'b0, e}, 32'd0);
    check_val("al_en", en_rises - n0, 32'd1);
    check_val("al_addr", {24'b0, last_addr}, 32'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
